pipe_id_stage: RTL

- Decode stage plus ID/EXE pipeline register of the 5-stage MIPS pipeline; the producer side of the EXE-stage input bundle (ealuc, ealuimm, ea, eb, eimm, esa, eshift, ern0, epc4, ejal).
- Decodes the instruction and selects forwarded operands from EXE/MEM.
- Detects load-use hazards and inserts one bubble.
- Resolves branches/jumps in ID (one delay slot, no flush) and registers everything into the E-stage outputs.

---
 rtl/pipe_id_stage_pkg.sv | 75 +++++++
 rtl/pipe_id_stage_fwd_unit.sv | 47 ++++
 rtl/pipe_id_stage.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_id_stage_pkg.sv
// Shared decode constants for the ID stage: opcodes, functs, ALU codes,
// next-PC selects and forwarding selects.
package pipe_id_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JR     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EXE  = 2'b01;
  localparam logic [1:0] FWD_MALU = 2'b10;
  localparam logic [1:0] FWD_MMO  = 2'b11;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic       jal;
    logic       shift;
    logic       aluimm;
    logic       sext;
    logic       regrt;
    logic       uses_rs;
    logic       uses_rt;
    logic [3:0] aluc;
  } ctrl_t;

  function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                          input logic [31:0] rf,
                                          input logic [31:0] exe,
                                          input logic [31:0] malu,
                                          input logic [31:0] mmo);
    case (sel)
      FWD_EXE:  return exe;
      FWD_MALU: return malu;
      FWD_MMO:  return mmo;
      default:  return rf;
    endcase
  endfunction

endpackage

// File: rtl/pipe_id_stage_fwd_unit.sv
// Operand forwarding selects and hazard stall for the rs/rt pair in ID.
module pipe_fwd_unit
  import pipe_id_stage_pkg::*;
#(
  parameter int FWD_EN = 1
) (
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       uses_rs,
  input  logic       uses_rt,
  input  logic [4:0] ern,
  input  logic       ewreg,
  input  logic       em2reg,
  input  logic [4:0] mrn,
  input  logic       mwreg,
  input  logic       mm2reg,
  output logic [1:0] fwda,
  output logic [1:0] fwdb,
  output logic       stall
);

  logic exe_hit_a, exe_hit_b, mem_hit_a, mem_hit_b;

  // r0 is hardwired zero, so a match on it never counts as a hit
  assign exe_hit_a = ewreg & (ern == rs) & (rs != 5'd0);
  assign exe_hit_b = ewreg & (ern == rt) & (rt != 5'd0);
  assign mem_hit_a = mwreg & (mrn == rs) & (rs != 5'd0);
  assign mem_hit_b = mwreg & (mrn == rt) & (rt != 5'd0);

  always_comb begin
    fwda  = FWD_RF;
    fwdb  = FWD_RF;
    stall = 1'b0;
    if (FWD_EN != 0) begin
      if (exe_hit_a & ~em2reg) fwda = FWD_EXE;
      else if (mem_hit_a)      fwda = mm2reg ? FWD_MMO : FWD_MALU;
      if (exe_hit_b & ~em2reg) fwdb = FWD_EXE;
      else if (mem_hit_b)      fwdb = mm2reg ? FWD_MMO : FWD_MALU;
      // a load result is not available until MEM, one cycle late
      stall = em2reg & ((exe_hit_a & uses_rs) | (exe_hit_b & uses_rt));
    end else begin
      stall = ((exe_hit_a | mem_hit_a) & uses_rs) |
              ((exe_hit_b | mem_hit_b) & uses_rt);
    end
  end

endmodule

// File: rtl/pipe_id_stage.sv
// MIPS decode stage with operand forwarding, load-use bubble, branch/jump
// resolution in ID and the ID/EXE pipeline register.
module pipe_id_stage
  import pipe_id_stage_pkg::*;
#(
  parameter int FWD_EN = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] dpc4,
  input  logic [31:0] inst,
  input  logic [31:0] qa,
  input  logic [31:0] qb,
  input  logic [31:0] ealu,
  input  logic [4:0]  mrn,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic [31:0] malu,
  input  logic [31:0] mmo,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic        wpcir,
  output logic [1:0]  pcsource,
  output logic [31:0] bpc,
  output logic [31:0] jpc,
  output logic        ewreg,
  output logic        em2reg,
  output logic        ewmem,
  output logic        ejal,
  output logic        eshift,
  output logic        ealuimm,
  output logic [3:0]  ealuc,
  output logic [31:0] ea,
  output logic [31:0] eb,
  output logic [31:0] eimm,
  output logic [31:0] esa,
  output logic [31:0] epc4,
  output logic [4:0]  ern0
);

  logic [5:0]  op, fn;
  logic [4:0]  rd, ern;
  logic [15:0] imm;
  ctrl_t       c;
  logic        is_jr, is_beq, is_bne, is_jmp, r_alu, i_alu;
  logic [1:0]  fwda, fwdb;
  logic        stall, taken;
  logic [31:0] fa, fb, imm_ext;

  assign op  = inst[31:26];
  assign fn  = inst[5:0];
  assign rd  = inst[15:11];
  assign imm = inst[15:0];
  assign rs  = inst[25:21];
  assign rt  = inst[20:16];

  always_comb begin
    c      = '0;
    is_jr  = 1'b0;
    is_beq = 1'b0;
    is_bne = 1'b0;
    is_jmp = 1'b0;
    r_alu  = 1'b0;
    i_alu  = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD: begin r_alu = 1'b1; c.aluc = ALU_ADD; end
          FN_SUB: begin r_alu = 1'b1; c.aluc = ALU_SUB; end
          FN_AND: begin r_alu = 1'b1; c.aluc = ALU_AND; end
          FN_OR:  begin r_alu = 1'b1; c.aluc = ALU_OR;  end
          FN_XOR: begin r_alu = 1'b1; c.aluc = ALU_XOR; end
          FN_SLL: begin r_alu = 1'b1; c.aluc = ALU_SLL; c.shift = 1'b1; end
          FN_SRL: begin r_alu = 1'b1; c.aluc = ALU_SRL; c.shift = 1'b1; end
          FN_SRA: begin r_alu = 1'b1; c.aluc = ALU_SRA; c.shift = 1'b1; end
          FN_JR:  begin is_jr = 1'b1; c.uses_rs = 1'b1; end
          default: ;
        endcase
        if (r_alu) begin
          c.wreg    = 1'b1;
          c.uses_rt = 1'b1;
          c.uses_rs = ~c.shift;
        end
      end
      OP_ADDI: begin i_alu = 1'b1; c.sext = 1'b1; c.aluc = ALU_ADD; end
      OP_ANDI: begin i_alu = 1'b1; c.aluc = ALU_AND; end
      OP_ORI:  begin i_alu = 1'b1; c.aluc = ALU_OR;  end
      OP_XORI: begin i_alu = 1'b1; c.aluc = ALU_XOR; end
      OP_LW:   begin i_alu = 1'b1; c.sext = 1'b1; c.m2reg = 1'b1; c.aluc = ALU_ADD; end
      OP_LUI:  begin
        c.wreg = 1'b1; c.aluimm = 1'b1; c.regrt = 1'b1; c.aluc = ALU_LUI;
      end
      OP_SW:   begin
        c.wmem = 1'b1; c.aluimm = 1'b1; c.sext = 1'b1;
        c.uses_rs = 1'b1; c.uses_rt = 1'b1; c.aluc = ALU_ADD;
      end
      OP_BEQ:  begin
        is_beq = 1'b1; c.sext = 1'b1; c.uses_rs = 1'b1; c.uses_rt = 1'b1; c.aluc = ALU_SUB;
      end
      OP_BNE:  begin
        is_bne = 1'b1; c.sext = 1'b1; c.uses_rs = 1'b1; c.uses_rt = 1'b1; c.aluc = ALU_SUB;
      end
      OP_J:    is_jmp = 1'b1;
      OP_JAL:  begin is_jmp = 1'b1; c.jal = 1'b1; c.wreg = 1'b1; end
      default: ;
    endcase
    if (i_alu) begin
      c.wreg    = 1'b1;
      c.aluimm  = 1'b1;
      c.regrt   = 1'b1;
      c.uses_rs = 1'b1;
    end
  end

  // jal's link register is substituted here so EXE can keep ern0 generic
  assign ern = ejal ? 5'd31 : ern0;

  pipe_fwd_unit #(.FWD_EN(FWD_EN)) u_fwd (
    .rs      (rs),
    .rt      (rt),
    .uses_rs (c.uses_rs),
    .uses_rt (c.uses_rt),
    .ern     (ern),
    .ewreg   (ewreg),
    .em2reg  (em2reg),
    .mrn     (mrn),
    .mwreg   (mwreg),
    .mm2reg  (mm2reg),
    .fwda    (fwda),
    .fwdb    (fwdb),
    .stall   (stall)
  );

  assign fa      = fwd_mux(fwda, qa, ealu, malu, mmo);
  assign fb      = fwd_mux(fwdb, qb, ealu, malu, mmo);
  assign imm_ext = c.sext ? {{16{imm[15]}}, imm} : {16'b0, imm};
  assign bpc     = dpc4 + {imm_ext[29:0], 2'b00};
  assign jpc     = is_jr ? fa : {dpc4[31:28], inst[25:0], 2'b00};
  assign taken   = (is_beq & (fa == fb)) | (is_bne & (fa != fb));
  assign wpcir   = ~stall;

  always_comb begin
    pcsource = PC_SEQ;
    if (!stall) begin
      if (taken)       pcsource = PC_BRANCH;
      else if (is_jr)  pcsource = PC_JR;
      else if (is_jmp) pcsource = PC_JUMP;
    end
  end

  // a stalled instruction is replayed next cycle, so EXE sees an all-zero bubble
  always_ff @(posedge clock) begin
    if (!resetn || stall) begin
      ewreg   <= 1'b0;
      em2reg  <= 1'b0;
      ewmem   <= 1'b0;
      ejal    <= 1'b0;
      eshift  <= 1'b0;
      ealuimm <= 1'b0;
      ealuc   <= 4'b0;
      ea      <= 32'b0;
      eb      <= 32'b0;
      eimm    <= 32'b0;
      esa     <= 32'b0;
      epc4    <= 32'b0;
      ern0    <= 5'b0;
    end else begin
      ewreg   <= c.wreg;
      em2reg  <= c.m2reg;
      ewmem   <= c.wmem;
      ejal    <= c.jal;
      eshift  <= c.shift;
      ealuimm <= c.aluimm;
      ealuc   <= c.aluc;
      ea      <= fa;
      eb      <= fb;
      eimm    <= imm_ext;
      esa     <= {27'b0, inst[10:6]};
      epc4    <= dpc4;
      ern0    <= c.regrt ? rt : rd;
    end
  end

endmodule
